mp_pma_rcv_det_resp: RTL and testbench

//  PMA-side responder for the PCS receiver-detect handshake. Accepts pma_rcv_detect,

---
 rtl/mp_pma_rcv_det_resp.sv | 147 ++++++++++++++
 tb/tb_mp_pma_rcv_det_resp.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mp_pma_rcv_det_resp.sv
// PMA-side receiver-detect responder: sequences the AFE detect circuit for a PCS request.
// Build option: define MP_RCV_DET_MAJORITY_EN for an SMPL_NUM-sample majority vote.
module mp_pma_rcv_det_resp #(
   parameter int CNT_W    = 12,
   parameter int SMPL_NUM = 5
) (
   input  logic             ref_clk,
   input  logic             ref_rst_n,
   input  logic             pma_rcv_detect,
   output logic             pma_rcv_detect_done,
   output logic             pma_rcv_detected,
   input  logic [CNT_W-1:0] cfg_settle_cnt,
   input  logic [CNT_W-1:0] cfg_charge_cnt,
   input  logic [CNT_W-1:0] cfg_recover_cnt,
   input  logic             afe_det_cmp,
   output logic             afe_det_cmp_en,
   output logic             afe_det_drv_en,
   output logic             rcv_det_busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_STEP,
      ST_SAMPLE,
      ST_DONE,
      ST_RECOVER
   } state_t;

   if (SMPL_NUM < 1 || SMPL_NUM > 15 || (SMPL_NUM % 2) == 0) begin : g_bad_smpl_num
      $error("SMPL_NUM must be odd and in 1..15");
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q, req_d;
   logic             cmp_meta_q, cmp_meta_d;
   logic             cmp_sync_q, cmp_sync_d;
   logic             detected_q, detected_d;
   logic [CNT_W-1:0] smpl_load;

`ifdef MP_RCV_DET_MAJORITY_EN
   localparam int VOTE_W = $clog2(SMPL_NUM + 1);
   logic [VOTE_W-1:0] vote_q, vote_d, vote_total;
   assign smpl_load  = CNT_W'(SMPL_NUM - 1);
   assign vote_total = vote_q + VOTE_W'(cmp_sync_q);
`else
   assign smpl_load  = '0;
`endif

   always_ff @(posedge ref_clk) begin
      // NOTE: synchronous reset clears every flop, including the synchronizer stages.
      if (!ref_rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         cmp_meta_q <= 1'b0;
         cmp_sync_q <= 1'b0;
         detected_q <= 1'b0;
`ifdef MP_RCV_DET_MAJORITY_EN
         vote_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         cmp_meta_q <= cmp_meta_d;
         cmp_sync_q <= cmp_sync_d;
         detected_q <= detected_d;
`ifdef MP_RCV_DET_MAJORITY_EN
         vote_q     <= vote_d;
`endif
      end
   end

   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      detected_d = detected_q;
      req_d      = pma_rcv_detect;
      cmp_meta_d = afe_det_cmp;
      cmp_sync_d = cmp_meta_q;
`ifdef MP_RCV_DET_MAJORITY_EN
      vote_d     = vote_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (req_q) begin
               state_d = ST_SETTLE;
               cnt_d   = cfg_settle_cnt;
            end
         end
         ST_SETTLE, ST_STEP, ST_SAMPLE: begin
            // A withdrawn request aborts the detect before any result is published.
            if (!req_q) begin
               state_d = ST_RECOVER;
               cnt_d   = cfg_recover_cnt;
            end else if (state_q == ST_SAMPLE) begin
`ifdef MP_RCV_DET_MAJORITY_EN
               vote_d = vote_total;
`endif
               if (cnt_q == '0) begin
                  state_d = ST_DONE;
`ifdef MP_RCV_DET_MAJORITY_EN
                  detected_d = (vote_total > VOTE_W'(SMPL_NUM / 2));
`else
                  detected_d = cmp_sync_q;
`endif
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (state_q == ST_SETTLE) begin
               state_d = ST_STEP;
               cnt_d   = cfg_charge_cnt;
            end else begin
               state_d = ST_SAMPLE;
               cnt_d   = smpl_load;
`ifdef MP_RCV_DET_MAJORITY_EN
               vote_d  = '0;
`endif
            end
         end
         ST_DONE: begin
            if (!req_q) begin
               state_d    = ST_RECOVER;
               cnt_d      = cfg_recover_cnt;
               detected_d = 1'b0;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pma_rcv_detect_done = (state_q == ST_DONE);
   assign pma_rcv_detected    = detected_q;
   assign afe_det_cmp_en      = (state_q == ST_SETTLE) || (state_q == ST_STEP) || (state_q == ST_SAMPLE);
   assign afe_det_drv_en      = (state_q == ST_STEP) || (state_q == ST_SAMPLE);
   assign rcv_det_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mp_pma_rcv_det_resp.sv
// Self-checking bench for mp_pma_rcv_det_resp: directed table, chained/reset sequences,
// and randomized transactions checked cycle-by-cycle against a timeline model.
module tb_mp_pma_rcv_det_resp;

   localparam int CNT_W    = 12;
   localparam int SMPL_NUM = 5;
`ifdef MP_RCV_DET_MAJORITY_EN
   localparam int N = SMPL_NUM;
`else
   localparam int N = 1;
`endif

   logic             ref_clk = 1'b0;
   logic             ref_rst_n;
   logic             req;
   logic             afe_cmp;
   logic [CNT_W-1:0] cfg_s, cfg_c, cfg_r;
   logic             done, detected, cmp_en, drv_en, busy;

   int checks   = 0;
   int failures = 0;
   int edge_cnt = 0;

   mp_pma_rcv_det_resp #(.CNT_W(CNT_W), .SMPL_NUM(SMPL_NUM)) dut (
      .ref_clk             (ref_clk),
      .ref_rst_n           (ref_rst_n),
      .pma_rcv_detect      (req),
      .pma_rcv_detect_done (done),
      .pma_rcv_detected    (detected),
      .cfg_settle_cnt      (cfg_s),
      .cfg_charge_cnt      (cfg_c),
      .cfg_recover_cnt     (cfg_r),
      .afe_det_cmp         (afe_cmp),
      .afe_det_cmp_en      (cmp_en),
      .afe_det_drv_en      (drv_en),
      .rcv_det_busy        (busy)
   );

   always #5 ref_clk = ~ref_clk;
   always @(posedge ref_clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      string      name;
      int         s, c, r;
      bit         abort;
      int         off;
      int         hold;
      int         mode;
      logic [15:0] pat;
      logic       exp_det;
      int         exp_lat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge ref_clk);
      @(negedge ref_clk);
   endtask

   function automatic logic [4:0] outs();
      return {busy, cmp_en, drv_en, done, detected};
   endfunction

   // Request is sampled high at edge t0 and low at edge t1. Timeline: SETTLE starts at
   // t0+1, STEP at t0+s+2, DONE at t0+s+c+N+3; RECOVER starts at t1+1, IDLE at t1+r+2.
   // Comparator value driven after edge n is the sample used at edge n+3.
   task automatic run_txn(input string tag, input int s, input int c, input int r,
                          input bit abort, input int off, input int hold, input int mode,
                          input logic [15:0] pat, input bit chain_in, input bit chain_out,
                          output int lat, output logic det);
      int   t0, t1, l, e, o, ones, act_end;
      bit   hist[0:255];
      logic a, maj, x_done;
      logic [4:0] exp_v;
      l   = s + c + N + 3;
      t0  = chain_in ? edge_cnt : edge_cnt + 1;
      t1  = abort ? t0 + off : t0 + l + hold;
      act_end = abort ? t1 + 1 : t0 + l;
      cfg_s = CNT_W'(s);
      cfg_c = CNT_W'(c);
      cfg_r = CNT_W'(r);
      lat = -1;
      det = 1'b0;
      e   = edge_cnt;
      for (int k = 0; k < 400; k++) begin
         o = e - t0;
         if (mode == 1) a = 1'b1;
         else if (mode == 2 && o >= s + c + 1 && o <= s + c + N) a = pat[o - s - c - 1];
         else a = 1'($urandom_range(0, 1));
         afe_cmp = a;
         if (o >= 0) hist[o] = a;
         req = ((e + 1 >= t0) && (e + 1 < t1)) || (chain_out && (e + 1 >= t1 + 2));
         next_cycle();
         e = edge_cnt;
         o = e - t0;
         x_done = !abort && (e >= t0 + l) && (e < t1 + 1);
         maj = 1'b0;
         if (x_done) begin
            ones = 0;
            for (int j = 1; j <= N; j++) ones += int'(hist[s + c + j]);
            maj = (ones > N / 2);
         end
         exp_v[4] = (e >= t0 + 1) && (e < t1 + r + 2);
         exp_v[3] = (e >= t0 + 1) && (e < act_end);
         exp_v[2] = exp_v[3] && (e >= t0 + s + 2);
         exp_v[1] = x_done;
         exp_v[0] = x_done && maj;
         check($sformatf("%s outs@%0d", tag, o), 32'(outs()), 32'(exp_v));
         if (done === 1'b1 && lat < 0) begin
            lat = o;
            det = detected;
         end
         if (e == t1 + r + 2) break;
         if (k == 399) check($sformatf("%s timeout", tag), 32'd1, 32'd0);
      end
   endtask

   initial begin
      int   lat, l;
      logic det;

      vecs[0]  = '{"cmp_hi",      4, 10, 3, 1'b0, 0, 2, 1, 16'h0000, 1'b1, 0};
      vecs[1]  = '{"pat10100",    4, 10, 3, 1'b0, 0, 1, 2, 16'h0005, 1'b0, 0};
      vecs[2]  = '{"pat11010",    4, 10, 3, 1'b0, 0, 1, 2, 16'h000B, 1'b1, 0};
      vecs[3]  = '{"zero_cfg",    0,  0, 0, 1'b0, 0, 1, 1, 16'h0000, 1'b1, 0};
      vecs[4]  = '{"abort_step",  4, 10, 2, 1'b1, 9, 0, 1, 16'h0000, 1'b0, -1};
      vecs[5]  = '{"pat01111",    2,  3, 1, 1'b0, 0, 3, 2, 16'h001E, 1'b1, 0};
      vecs[6]  = '{"pat11100",    0,  0, 1, 1'b0, 0, 1, 2, 16'h0007, 1'b1, 0};
      vecs[7]  = '{"pat00011",    0,  0, 1, 1'b0, 0, 1, 2, 16'h0018, 1'b0, 0};
      vecs[8]  = '{"abort_settle",4, 10, 1, 1'b1, 1, 0, 1, 16'h0000, 1'b0, -1};
      vecs[9]  = '{"abort_lastsm",3,  2, 1, 1'b1, 3 + 2 + N + 2, 0, 1, 16'h0000, 1'b0, -1};
      vecs[10] = '{"all_zero",    1,  1, 0, 1'b0, 0, 2, 2, 16'h0000, 1'b0, 0};
`ifndef MP_RCV_DET_MAJORITY_EN
      // Single-sample build: only the first SAMPLE-cycle comparator value matters.
      vecs[1].exp_det = 1'b1;
      vecs[5].exp_det = 1'b0;
`endif
      foreach (vecs[i]) if (!vecs[i].abort) vecs[i].exp_lat = vecs[i].s + vecs[i].c + N + 3;

      ref_rst_n = 1'b0;
      req       = 1'b0;
      afe_cmp   = 1'b0;
      cfg_s     = '0;
      cfg_c     = '0;
      cfg_r     = '0;
      @(negedge ref_clk);
      repeat (3) next_cycle();
      check("reset outs", 32'(outs()), 32'd0);
      ref_rst_n = 1'b1;
      repeat (2) next_cycle();
      check("idle after reset", 32'(outs()), 32'd0);

      for (int i = 0; i < 11; i++) begin
         run_txn(vecs[i].name, vecs[i].s, vecs[i].c, vecs[i].r, vecs[i].abort, vecs[i].off,
                 vecs[i].hold, vecs[i].mode, vecs[i].pat, 1'b0, 1'b0, lat, det);
         check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
         check({vecs[i].name, " detected"}, 32'(det), 32'(vecs[i].exp_det));
      end

      // Request re-raised during RECOVER: ignored until IDLE, then one new sequence.
      run_txn("rereq_a", 2, 3, 8, 1'b0, 0, 1, 1, 16'h0, 1'b0, 1'b1, lat, det);
      check("rereq_a latency", 32'(lat), 32'(2 + 3 + N + 3));
      run_txn("rereq_b", 2, 3, 2, 1'b0, 0, 2, 1, 16'h0, 1'b1, 1'b0, lat, det);
      check("rereq_b latency", 32'(lat), 32'(2 + 3 + N + 3));
      check("rereq_b detected", 32'(det), 32'd1);

      // Reset pulse in the middle of SAMPLE.
      begin
         int t0;
         cfg_s = CNT_W'(4);
         cfg_c = CNT_W'(10);
         cfg_r = CNT_W'(3);
         afe_cmp = 1'b1;
         t0  = edge_cnt + 1;
         req = 1'b1;
         for (int k = 0; k < 60 && edge_cnt < t0 + 4 + 10 + 3; k++) next_cycle();
         check("pre-reset drv_en", 32'(drv_en), 32'd1);
         ref_rst_n = 1'b0;
         next_cycle();
         check("mid reset outs", 32'(outs()), 32'd0);
         ref_rst_n = 1'b1;
         req = 1'b0;
         repeat (2) next_cycle();
         check("post reset outs", 32'(outs()), 32'd0);
         run_txn("after_rst", 4, 10, 3, 1'b0, 0, 1, 1, 16'h0, 1'b0, 1'b0, lat, det);
         check("after_rst latency", 32'(lat), 32'(4 + 10 + N + 3));
         check("after_rst detected", 32'(det), 32'd1);
      end

      for (int i = 0; i < 40; i++) begin
         int   s, c, r, off, hold;
         bit   abort;
         s     = $urandom_range(0, 15);
         c     = $urandom_range(0, 15);
         r     = $urandom_range(0, 10);
         l     = s + c + N + 3;
         abort = ($urandom_range(0, 3) == 0);
         off   = $urandom_range(1, l - 1);
         hold  = $urandom_range(1, 3);
         run_txn($sformatf("rnd%0d", i), s, c, r, abort, off, hold, 0, 16'h0, 1'b0, 1'b0,
                 lat, det);
         check($sformatf("rnd%0d latency", i), 32'(lat), abort ? 32'hFFFF_FFFF : 32'(l));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
